sseg_disp_ctrl: RTL and testbench



---
 rtl/sseg_pkg.sv | 12 +
 rtl/sseg_dec.sv | 37 +++
 rtl/sseg_disp_ctrl.sv | 115 +++++++++++
 tb/tb_sseg_disp_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the six-digit seven-segment display path.
//   DIGITS_DEF    : number of hex digits on the board
//   SEG_W         : segments per digit (gfedcba, no decimal point)
//   SEG_BLANK     : active-low pattern with every segment dark
//   BLINK_DIV_DEF : cursor half-period in clk cycles (0.5 s at 50 MHz)
package sseg_pkg;
   localparam int DIGITS_DEF    = 6;
   localparam int SEG_W         = 7;
   localparam int BLINK_DIV_DEF = 25_000_000;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
endpackage : sseg_pkg

// File: rtl/sseg_dec.sv
// Hex nibble to active-low seven-segment decoder, purely combinational.
//   nibble : hex value to show
//   en     : 0 forces the digit dark
//   led    : active-low segments, bit order gfedcba
module sseg_dec
   import sseg_pkg::*;
(
   input  logic [3:0]       nibble,
   input  logic             en,
   output logic [SEG_W-1:0] led
);

   always_comb begin
      led = SEG_BLANK;
      if (en) begin
         case (nibble)
            4'h0: led = 7'b1000000;
            4'h1: led = 7'b1111001;
            4'h2: led = 7'b0100100;
            4'h3: led = 7'b0110000;
            4'h4: led = 7'b0011001;
            4'h5: led = 7'b0010010;
            4'h6: led = 7'b0000010;
            4'h7: led = 7'b1111000;
            4'h8: led = 7'b0000000;
            4'h9: led = 7'b0010000;
            4'hA: led = 7'b0001000;
            4'hB: led = 7'b0000011;
            4'hC: led = 7'b1000110;
            4'hD: led = 7'b0100001;
            4'hE: led = 7'b0000110;
            default: led = 7'b0001110;
         endcase
      end
   end

endmodule : sseg_dec

// File: rtl/sseg_disp_ctrl.sv
// Display controller for the DE0-CV HEX digits. Two writers (0 = memory
// editor, 1 = CPU monitor) share the display through a round-robin
// valid/ready arbiter. The held value is shown with optional leading-zero
// blanking and a blinking edit cursor; segment outputs are registered.
//   clk, rst             : system clock, async active-high reset
//   s0_valid/data/ready  : editor write channel
//   s1_valid/data/ready  : monitor write channel
//   lzb                  : leading-zero blanking enable
//   cur_en, cur_pos      : cursor blink enable and digit index (>= DIGITS = none)
//   hex                  : registered active-low segments, digit i at [7i+6:7i]
module sseg_disp_ctrl
   import sseg_pkg::*;
#(
   parameter int DIGITS    = DIGITS_DEF,
   parameter int BLINK_DIV = BLINK_DIV_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s0_valid,
   input  logic [4*DIGITS-1:0]     s0_data,
   output logic                    s0_ready,
   input  logic                    s1_valid,
   input  logic [4*DIGITS-1:0]     s1_data,
   output logic                    s1_ready,
   input  logic                    lzb,
   input  logic                    cur_en,
   input  logic [2:0]              cur_pos,
   output logic [SEG_W*DIGITS-1:0] hex
);

   localparam int DW    = 4*DIGITS;
   localparam int HW    = SEG_W*DIGITS;
   localparam int BLK_W = $clog2(BLINK_DIV);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV-1);

   logic [DW-1:0]    disp_q, disp_d;
   logic             last_q, last_d;
   logic [BLK_W-1:0] blk_q, blk_d;
   logic             phase_q, phase_d;
   logic [HW-1:0]    hex_q, hex_d;
   logic [DIGITS-1:0] en;
   logic             xfer;
   logic             nz_above;

   // Ready is gated by rst so an in-flight write is dropped the moment
   // reset asserts, not at the next edge.
   assign s0_ready = !rst && s0_valid && (!s1_valid || last_q);
   assign s1_ready = !rst && s1_valid && (!s0_valid || !last_q);
   assign xfer     = s0_ready || s1_ready;

   always_comb begin
      disp_d = disp_q;
      last_d = last_q;
      if (s0_ready) begin
         disp_d = s0_data;
         last_d = 1'b0;
      end else if (s1_ready) begin
         disp_d = s1_data;
         last_d = 1'b1;
      end
   end

   // A fresh write restarts the cursor in its visible half so the edited
   // digit is never dark right after it changes.
   always_comb begin
      blk_d   = blk_q + 1'b1;
      phase_d = phase_q;
      if (xfer) begin
         blk_d   = '0;
         phase_d = 1'b1;
      end else if (blk_q == BLK_LAST) begin
         blk_d   = '0;
         phase_d = !phase_q;
      end
   end

   // Walk from the top digit down; nz_above goes high at the first
   // non-zero digit and stays high, so everything below it is shown.
   always_comb begin
      nz_above = 1'b0;
      en       = '0;
      for (int i = DIGITS-1; i >= 0; i--) begin
         nz_above = nz_above || (disp_q[4*i +: 4] != 4'h0);
         en[i] = !(lzb && (i > 0) && !nz_above) &&
                 !(cur_en && (cur_pos == 3'(i)) && !phase_q);
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      sseg_dec u_dec (
         .nibble (disp_q[4*g +: 4]),
         .en     (en[g]),
         .led    (hex_d[SEG_W*g +: SEG_W])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_q  <= '0;
         last_q  <= 1'b1;
         blk_q   <= '0;
         phase_q <= 1'b1;
         hex_q   <= {DIGITS{SEG_BLANK}};
      end else begin
         disp_q  <= disp_d;
         last_q  <= last_d;
         blk_q   <= blk_d;
         phase_q <= phase_d;
         hex_q   <= hex_d;
      end
   end

   assign hex = hex_q;

endmodule : sseg_disp_ctrl

// File: tb/tb_sseg_disp_ctrl.sv
module tb_sseg_disp_ctrl;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SC = 7'b1000110;

   logic        clk = 1'b0;
   logic        rst;
   logic        s0_valid, s1_valid;
   logic [23:0] s0_data, s1_data;
   logic        s0_ready, s1_ready;
   logic        lzb, cur_en;
   logic [2:0]  cur_pos;
   logic [41:0] hex;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sseg_disp_ctrl #(.DIGITS(6), .BLINK_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .s0_valid (s0_valid),
      .s0_data  (s0_data),
      .s0_ready (s0_ready),
      .s1_valid (s1_valid),
      .s1_data  (s1_data),
      .s1_ready (s1_ready),
      .lzb      (lzb),
      .cur_en   (cur_en),
      .cur_pos  (cur_pos),
      .hex      (hex)
   );

   task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; lzb = 1'b1; cur_en = 1'b0; cur_pos = 3'd7;
      s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;

      // reset held three cycles
      repeat (3) @(negedge clk);
      chk("rst_hex", hex, {6{BL}});
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rel_hex", hex, {BL, BL, BL, BL, BL, S0});
      chk("idle_r0", 42'(s0_ready), 42'd0);
      chk("idle_r1", 42'(s1_ready), 42'd0);

      // single editor write
      s0_valid = 1'b1; s0_data = 24'h00A5C3;
      #1;
      chk("sw_r0", 42'(s0_ready), 42'd1);
      chk("sw_r1", 42'(s1_ready), 42'd0);
      @(negedge clk);
      s0_valid = 1'b0;
      chk("sw_disp", 42'(dut.disp_q), 42'h00A5C3);
      chk("sw_hex_old", hex, {BL, BL, BL, BL, BL, S0});
      @(negedge clk);
      chk("sw_hex", hex, {BL, BL, SA, S5, SC, S3});

      // monitor write alone so last served becomes 1
      s1_valid = 1'b1; s1_data = 24'h000001;
      #1;
      chk("m_r1", 42'(s1_ready), 42'd1);
      @(negedge clk);
      s1_valid = 1'b0;

      // contention: expect 0,1,0,1
      s0_valid = 1'b1; s0_data = 24'h111111;
      s1_valid = 1'b1; s1_data = 24'h222222;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("ct_r0", 42'(s0_ready), (k % 2 == 0) ? 42'd1 : 42'd0);
         chk("ct_r1", 42'(s1_ready), (k % 2 == 1) ? 42'd1 : 42'd0);
         @(negedge clk);
         chk("ct_disp", 42'(dut.disp_q), (k % 2 == 0) ? 42'h111111 : 42'h222222);
      end
      s0_valid = 1'b0; s1_valid = 1'b0;
      @(negedge clk);
      chk("ct_hex", hex, {S2, S2, S2, S2, S2, S2});

      // cursor on digit 2, blink half-period 4
      s1_valid = 1'b1; s1_data = 24'h123456; cur_en = 1'b1; cur_pos = 3'd2;
      #1;
      chk("cu_r1", 42'(s1_ready), 42'd1);
      @(negedge clk);
      s1_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) chk("cu_hex", hex, {S1, S2, S3, S4, S5, S6});
         chk("cu_dig2", 42'(hex[20:14]), (k <= 4) ? 42'(S4) : 42'(BL));
      end
      s0_valid = 1'b1; s0_data = 24'h123456;
      #1;
      chk("cu_wr_r0", 42'(s0_ready), 42'd1);
      @(negedge clk);
      s0_valid = 1'b0;
      chk("cu_k7", 42'(hex[20:14]), 42'(BL));
      @(negedge clk);
      chk("cu_k8", 42'(hex[20:14]), 42'(S4));
      repeat (3) @(negedge clk);
      chk("cu_k11", 42'(hex[20:14]), 42'(S4));
      @(negedge clk);
      chk("cu_k12", 42'(hex[20:14]), 42'(BL));
      chk("cu_k12_d1", 42'(hex[13:7]), 42'(S5));

      // LZB toggle on an all-zero value
      cur_en = 1'b0; lzb = 1'b0;
      s0_valid = 1'b1; s0_data = 24'h000000;
      @(negedge clk);
      s0_valid = 1'b0;
      @(negedge clk);
      chk("lz_off", hex, {S0, S0, S0, S0, S0, S0});
      lzb = 1'b1;
      #1;
      chk("lz_hold", hex, {S0, S0, S0, S0, S0, S0});
      @(negedge clk);
      chk("lz_on", hex, {BL, BL, BL, BL, BL, S0});

      // async reset in the middle of a monitor write
      s1_valid = 1'b1; s1_data = 24'hABCDEF;
      #1;
      chk("ar_r1_pre", 42'(s1_ready), 42'd1);
      #1 rst = 1'b1;
      #1;
      chk("ar_r1", 42'(s1_ready), 42'd0);
      chk("ar_hex", hex, {6{BL}});
      chk("ar_disp", 42'(dut.disp_q), 42'd0);
      s1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ar_rel_hex", hex, {BL, BL, BL, BL, BL, S0});
      chk("ar_rel_disp", 42'(dut.disp_q), 42'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sseg_disp_ctrl
